// File: rtl/frame_tx_if.sv
// Link-side bundle for frame_tx: frame request inputs and serialised word outputs.
interface frame_tx_if;
  logic         start;
  logic [7:0]   ch_mask;
  logic [3:0]   len;
  logic [127:0] payload;
  logic         crc_corrupt;
  logic         ready;
  logic [15:0]  data_out;
  logic         frame_vld;
  logic         done;

  modport master (
    output start, ch_mask, len, payload, crc_corrupt,
    input  ready, data_out, frame_vld, done
  );

  modport slave (
    input  start, ch_mask, len, payload, crc_corrupt,
    output ready, data_out, frame_vld, done
  );
endinterface

// File: rtl/frame_tx.sv
// Frame generator: serialises HEAD/CTRL/DATA/CRC/TAIL words onto a 16-bit link,
// with a word-parallel CRC-16 (poly 0x1021, MSB first) over CTRL and DATA words.
module frame_tx (
  input  logic       clk_in,
  input  logic       rst_n,
  frame_tx_if.slave  link
);

  localparam int unsigned W         = 16;
  localparam int unsigned MAX_WORDS = 8;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned LEN_W     = 4;
  localparam int unsigned PL_W      = W * MAX_WORDS;

  localparam logic [W-1:0] HEAD_WORD = 16'hE0E0;
  localparam logic [W-1:0] TAIL_WORD = 16'h0E0E;
  localparam logic [W-1:0] IDLE_WORD = 16'h0000;
  localparam logic [W-1:0] CRC_INIT  = 16'hFFFF;
  localparam logic [W-1:0] CRC_POLY  = 16'h1021;

  // State names the word currently on data_out.
  typedef enum logic [2:0] {
    S_IDLE, S_HEAD, S_CTRL, S_DATA, S_CRC, S_TAIL
  } state_t;

  state_t           r_state;
  logic [7:0]       r_mask;
  logic [LEN_W-1:0] r_len;
  logic [PL_W-1:0]  r_payload;
  logic             r_corrupt;
  logic [W-1:0]     r_crc;
  logic [LEN_W-1:0] r_cnt;
  logic [W-1:0]     r_data;
  logic             r_vld;
  logic             r_done;
  logic             r_ready;

  logic             w_accept;
  logic [LEN_W-1:0] w_len_sat;
  logic [W-1:0]     w_ctrl;
  logic [IDX_W-1:0] w_sel;
  logic [W-1:0]     w_word;

  // Sixteen serial LFSR steps folded into one word update.
  function automatic logic [W-1:0] crc_step(input logic [W-1:0] crc, input logic [W-1:0] d);
    logic [W-1:0] c;
    logic         fb;
    c = crc;
    for (int i = W - 1; i >= 0; i--) begin
      fb = c[W-1] ^ d[i];
      c  = {c[W-2:0], 1'b0} ^ (fb ? CRC_POLY : {W{1'b0}});
    end
    return c;
  endfunction

  assign w_accept  = link.start & r_ready;
  assign w_len_sat = (link.len > LEN_W'(MAX_WORDS)) ? LEN_W'(MAX_WORDS) : link.len;
  assign w_ctrl    = {r_mask, 4'b0000, r_len};
  assign w_sel     = IDX_W'(MAX_WORDS - 1) - r_cnt[IDX_W-1:0];
  assign w_word    = r_payload[{w_sel, 4'b0000} +: W];

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_mask    <= '0;
      r_len     <= '0;
      r_payload <= '0;
      r_corrupt <= 1'b0;
      r_crc     <= CRC_INIT;
      r_cnt     <= '0;
      r_data    <= IDLE_WORD;
      r_vld     <= 1'b0;
      r_done    <= 1'b0;
      r_ready   <= 1'b1;
    end else begin
      case (r_state)
        S_HEAD: begin
          r_state <= S_CTRL;
          r_data  <= w_ctrl;
          r_crc   <= crc_step(r_crc, w_ctrl);
          r_cnt   <= '0;
        end
        S_CTRL, S_DATA: begin
          if (r_cnt == r_len) begin
            r_state <= S_CRC;
            r_data  <= r_crc ^ {{(W-1){1'b0}}, r_corrupt};
          end else begin
            r_state <= S_DATA;
            r_data  <= w_word;
            r_crc   <= crc_step(r_crc, w_word);
            r_cnt   <= r_cnt + LEN_W'(1);
          end
        end
        S_CRC: begin
          r_state <= S_TAIL;
          r_data  <= TAIL_WORD;
          r_done  <= 1'b1;
          r_ready <= 1'b1;
        end
        default: begin
          // IDLE and TAIL both accept; TAIL -> HEAD gives back-to-back frames.
          if (w_accept) begin
            r_mask    <= link.ch_mask;
            r_len     <= w_len_sat;
            r_payload <= link.payload;
            r_corrupt <= link.crc_corrupt;
            r_crc     <= CRC_INIT;
            r_state   <= S_HEAD;
            r_data    <= HEAD_WORD;
            r_vld     <= 1'b1;
            r_done    <= 1'b0;
            r_ready   <= 1'b0;
          end else begin
            r_state <= S_IDLE;
            r_data  <= IDLE_WORD;
            r_vld   <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
          end
        end
      endcase
    end
  end

  assign link.ready     = r_ready;
  assign link.data_out  = r_data;
  assign link.frame_vld = r_vld;
  assign link.done      = r_done;

endmodule

// File: tb/tb_frame_tx.sv
// Scoreboard bench for frame_tx: stimulus queues expected frame words, a monitor
// compares them against the link on every falling edge.
module tb_frame_tx;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  typedef struct packed {
    logic [15:0] w;
    logic        last;
  } exp_t;

  exp_t exp_q[$];

  frame_tx_if bus();

  frame_tx dut (
    .clk_in (clk),
    .rst_n  (rst_n),
    .link   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, want);
    end
  endtask

  // Reference CRC: whole word folded in first, then 16 shifts.
  function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [15:0] w);
    logic [15:0] r;
    r = c ^ w;
    for (int i = 0; i < 16; i++)
      r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  task automatic push_frame(input logic [7:0] mask, input logic [3:0] len,
                            input logic [127:0] pl, input logic corr);
    logic [3:0]   ls;
    logic [15:0]  ctrl;
    logic [15:0]  c;
    logic [15:0]  w;
    logic [127:0] sh;
    exp_t         e;
    ls   = (len > 4'd8) ? 4'd8 : len;
    ctrl = {mask, 4'b0000, ls};
    e = '{w: 16'hE0E0, last: 1'b0}; exp_q.push_back(e);
    e = '{w: ctrl,     last: 1'b0}; exp_q.push_back(e);
    c  = crc_ref(16'hFFFF, ctrl);
    sh = pl;
    for (int k = 0; k < int'(ls); k++) begin
      w  = sh[127:112];
      sh = sh << 16;
      e  = '{w: w, last: 1'b0}; exp_q.push_back(e);
      c  = crc_ref(c, w);
    end
    e = '{w: c ^ {15'b0, corr}, last: 1'b0}; exp_q.push_back(e);
    e = '{w: 16'h0E0E,          last: 1'b1}; exp_q.push_back(e);
  endtask

  task automatic wait_ready();
    int g = 0;
    @(negedge clk);
    while (!bus.ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) begin
      checks++; failures++;
      $display("FAIL wait_ready timeout got=busy want=ready");
    end
  endtask

  task automatic issue(input logic [7:0] mask, input logic [3:0] len,
                       input logic [127:0] pl, input logic corr);
    wait_ready();
    push_frame(mask, len, pl, corr);
    bus.start = 1'b1; bus.ch_mask = mask; bus.len = len;
    bus.payload = pl; bus.crc_corrupt = corr;
    @(posedge clk); #1;
    // Scramble inputs after accept so any missing latch shows up.
    bus.start = 1'b0; bus.ch_mask = ~mask; bus.len = ~len;
    bus.payload = ~pl; bus.crc_corrupt = ~corr;
  endtask

  task automatic wait_idle();
    int g = 0;
    @(negedge clk); #1;
    while ((exp_q.size() != 0 || bus.frame_vld) && g < 300) begin
      @(negedge clk); #1;
      g++;
    end
    if (g >= 300) begin
      checks++; failures++;
      $display("FAIL wait_idle timeout got=pending=%0d want=0", exp_q.size());
    end
  endtask

  // Monitor: every frame word is popped and compared; idle cycles must be quiet.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      chk("ready_rule", 16'(bus.ready), 16'(!bus.frame_vld || bus.done));
      if (bus.frame_vld) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_word got=%h want=no_frame", bus.data_out);
        end else begin
          e = exp_q.pop_front();
          chk("frame_word", bus.data_out, e.w);
          chk("done_flag", 16'(bus.done), 16'(e.last));
        end
      end else begin
        chk("idle_word", bus.data_out, 16'h0000);
        chk("idle_done", 16'(bus.done), 16'h0000);
      end
    end
  end

  initial begin
    logic [127:0] pat;
    int nd;
    int g;
    pat = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    bus.start = 1'b0; bus.ch_mask = '0; bus.len = '0;
    bus.payload = '0; bus.crc_corrupt = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_data", bus.data_out, 16'h0000);
    chk("rst_vld", 16'(bus.frame_vld), 16'h0000);
    chk("rst_ready", 16'(bus.ready), 16'h0001);
    chk("rst_done", 16'(bus.done), 16'h0000);

    // Start while in reset: reset wins.
    bus.start = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_start_vld", 16'(bus.frame_vld), 16'h0000);
    bus.start = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;

    // T2
    issue(8'h03, 4'd2, {32'h1234_5678, 96'h0}, 1'b0);
    wait_idle();
    // T3
    issue(8'h80, 4'd0, 128'hDEAD_BEEF, 1'b0);
    wait_idle();
    // T4
    issue(8'h5A, 4'd15, pat, 1'b0);
    wait_idle();
    // T6
    issue(8'h03, 4'd2, {32'h1234_5678, 96'h0}, 1'b1);
    wait_idle();

    // Start pulses while busy are dropped.
    issue(8'h11, 4'd1, {16'hABCD, 112'h0}, 1'b0);
    @(negedge clk); bus.start = 1'b1; bus.len = 4'd3;
    @(negedge clk); bus.start = 1'b0;
    wait_idle();

    // T5: start held across two frames, second one back-to-back.
    wait_ready();
    push_frame(8'h0F, 4'd1, {16'hCAFE, 112'h0}, 1'b0);
    push_frame(8'hF0, 4'd3, {48'h0102_0304_0506, 80'h0}, 1'b0);
    bus.start = 1'b1; bus.ch_mask = 8'h0F; bus.len = 4'd1;
    bus.payload = {16'hCAFE, 112'h0}; bus.crc_corrupt = 1'b0;
    @(posedge clk); #1;
    bus.ch_mask = 8'hF0; bus.len = 4'd3; bus.payload = {48'h0102_0304_0506, 80'h0};
    nd = 0; g = 0;
    while (nd < 2 && g < 100) begin
      @(negedge clk);
      if (bus.done) nd++;
      g++;
    end
    bus.start = 1'b0;
    if (nd < 2) begin
      checks++; failures++;
      $display("FAIL b2b_done got=%0d want=2", nd);
    end
    wait_idle();

    // T1: reset mid-DATA truncates the frame immediately.
    issue(8'hFF, 4'd8, pat, 1'b0);
    @(posedge clk); @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_data", bus.data_out, 16'h0000);
    chk("midrst_vld", 16'(bus.frame_vld), 16'h0000);
    chk("midrst_ready", 16'(bus.ready), 16'h0001);
    chk("midrst_done", 16'(bus.done), 16'h0000);
    exp_q.delete();
    @(posedge clk); #2 rst_n = 1'b1;

    // Recovery frame after reset.
    issue(8'h03, 4'd2, {32'h1234_5678, 96'h0}, 1'b0);
    wait_idle();
    repeat (3) @(negedge clk);

    chk("queue_drained", 16'(exp_q.size()), 16'h0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
